dvp_raw_frontend: RTL and testbench

Camera front-end between the image sensor and the ISP pipeline. It generates the sensor master clock from the 50 MHz board clock and a lock indication. It synchronises reset into the sensor pixel-clock domain. It captures the 8-bit RAW DVP stream, discarding the first frames after reset, and presents it with valid/sync flags and pixel coordinates.

---
 rtl/dvp_raw_frontend_if.sv | 24 ++
 rtl/dvp_raw_frontend.sv | 198 +++++++++++++++++++
 tb/tb_dvp_raw_frontend.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_raw_frontend_if.sv
// DVP sensor input bus and the captured pixel stream of dvp_raw_frontend.
// master = the front-end itself, slave = sensor model / downstream ISP.
interface dvp_raw_frontend_if;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic        data_clk;
  logic        data_valid;
  logic [7:0]  data_pixel;
  logic        data_hs;
  logic        data_vs;
  logic [11:0] xaddr;
  logic [11:0] yaddr;

  modport master (
    input  vsync, href, data,
    output data_clk, data_valid, data_pixel, data_hs, data_vs, xaddr, yaddr
  );

  modport slave (
    output vsync, href, data,
    input  data_clk, data_valid, data_pixel, data_hs, data_vs, xaddr, yaddr
  );
endinterface

// File: rtl/dvp_raw_frontend.sv
// Camera front-end: sensor master clock and lock, pclk reset synchroniser,
// and RAW DVP capture that drops the first FRAME_SKIP frames after reset.
module dvp_raw_frontend #(
  parameter int XCLK_DIV    = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int FRAME_SKIP  = 10
) (
  input  logic               clk50m,
  input  logic               reset_n,
  input  logic               pclk,
  dvp_raw_frontend_if.master dvp,
  output logic               xclk,
  output logic               xclk_lock,
  output logic               pclk_rst_n,
  output logic               image_state
);

  localparam logic [15:0] HALF_M1 = 16'(XCLK_DIV / 2 - 1);
  localparam logic [31:0] LOCK_M1 = 32'(LOCK_CYCLES - 1);
  localparam logic [15:0] SKIP_M1 = 16'(FRAME_SKIP - 1);
  localparam logic [15:0] SKIP_N  = 16'(FRAME_SKIP);

  // SKIP encodes as 0 so an all-zero power-up matches the reset state
  typedef enum logic {
    ST_SKIP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [15:0] div_cnt_r;
  logic        xclk_r;
  logic [31:0] lock_cnt_r;
  logic        lock_r;
  logic        rst_src_s;
  logic [1:0]  sync_r;

  logic        r_vs_r;
  logic        r_hs_r;
  logic        vs_rise_s;
  logic        hs_rise_s;
  logic [15:0] frame_cnt_r;
  state_t      state_r;
  state_t      state_nx_s;
  logic        en_s;
  logic        image_state_s;
  logic        pix_ok_s;

  logic        data_valid_r;
  logic [7:0]  data_pixel_r;
  logic        data_hs_r;
  logic        data_vs_r;
  logic [11:0] xaddr_r;
  logic [11:0] yaddr_r;

  // xclk divider: toggle every XCLK_DIV/2 clk50m cycles
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_r <= 16'd0;
      xclk_r    <= 1'b0;
    end else if (div_cnt_r == HALF_M1) begin
      div_cnt_r <= 16'd0;
      xclk_r    <= ~xclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + 16'd1;
      xclk_r    <= xclk_r;
    end
  end

  // lock timer: sticky once LOCK_CYCLES edges have elapsed since release
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      lock_cnt_r <= 32'd0;
      lock_r     <= 1'b0;
    end else if (!lock_r) begin
      lock_cnt_r <= lock_cnt_r + 32'd1;
      lock_r     <= (lock_cnt_r == LOCK_M1);
    end else begin
      lock_cnt_r <= lock_cnt_r;
      lock_r     <= 1'b1;
    end
  end

  assign rst_src_s = reset_n & lock_r;

  // pclk reset synchroniser: asserts at once, releases after two pclk edges
  always_ff @(posedge pclk or negedge rst_src_s) begin
    if (!rst_src_s) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], 1'b1};
    end
  end

  assign pclk_rst_n = sync_r[1];
  assign xclk       = xclk_r;
  assign xclk_lock  = lock_r;

  // input stage: previous vsync/href for edge detection
  always_ff @(posedge pclk or negedge pclk_rst_n) begin
    if (!pclk_rst_n) begin
      r_vs_r <= 1'b0;
      r_hs_r <= 1'b0;
    end else begin
      r_vs_r <= dvp.vsync;
      r_hs_r <= dvp.href;
    end
  end

  assign vs_rise_s = dvp.vsync & ~r_vs_r;
  assign hs_rise_s = dvp.href & ~r_hs_r;

  // frame counter, saturating at FRAME_SKIP
  always_ff @(posedge pclk or negedge pclk_rst_n) begin
    if (!pclk_rst_n) begin
      frame_cnt_r <= 16'd0;
    end else if (vs_rise_s && (frame_cnt_r != SKIP_N)) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // skip state register
  always_ff @(posedge pclk or negedge pclk_rst_n) begin
    if (!pclk_rst_n) begin
      state_r <= ST_SKIP;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // next state: leave SKIP on the vsync edge that completes the count
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_SKIP: begin
        if (vs_rise_s && (frame_cnt_r == SKIP_M1)) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_SKIP;
        end
      end
      ST_RUN:  state_nx_s = ST_RUN;
      default: state_nx_s = ST_SKIP;
    endcase
  end

  // gating from the next state, so the vsync that ends skipping passes whole
  always_comb begin
    image_state_s = 1'b1;
    case (state_r)
      ST_SKIP: image_state_s = 1'b1;
      ST_RUN:  image_state_s = 1'b0;
      default: image_state_s = 1'b1;
    endcase
    en_s = (state_nx_s == ST_RUN);
  end

  assign image_state = image_state_s;
  assign pix_ok_s    = dvp.href & en_s;

  // capture: flags, pixel and coordinates one pclk after the sample
  always_ff @(posedge pclk or negedge pclk_rst_n) begin
    if (!pclk_rst_n) begin
      data_valid_r <= 1'b0;
      data_pixel_r <= 8'd0;
      data_hs_r    <= 1'b0;
      data_vs_r    <= 1'b0;
      xaddr_r      <= 12'd0;
      yaddr_r      <= 12'd0;
    end else begin
      data_vs_r    <= dvp.vsync & en_s;
      data_hs_r    <= pix_ok_s;
      data_valid_r <= pix_ok_s;
      data_pixel_r <= pix_ok_s ? dvp.data : 8'd0;
      if (pix_ok_s) begin
        xaddr_r <= data_valid_r ? (xaddr_r + 12'd1) : 12'd1;
      end else begin
        xaddr_r <= 12'd0;
      end
      if (dvp.vsync) begin
        yaddr_r <= 12'd0;
      end else if (hs_rise_s && en_s) begin
        yaddr_r <= yaddr_r + 12'd1;
      end else begin
        yaddr_r <= yaddr_r;
      end
    end
  end

  assign dvp.data_clk   = pclk;
  assign dvp.data_valid = data_valid_r;
  assign dvp.data_pixel = data_pixel_r;
  assign dvp.data_hs    = data_hs_r;
  assign dvp.data_vs    = data_vs_r;
  assign dvp.xaddr      = xaddr_r;
  assign dvp.yaddr      = yaddr_r;

endmodule

// File: tb/tb_dvp_raw_frontend.sv
// Directed bench for dvp_raw_frontend: clock/lock, reset sync, frame skip,
// capture, coordinate wrap, vsync/href overlap and mid-line reset.
module tb_dvp_raw_frontend;
  logic clk50m = 1'b0;
  logic pclk   = 1'b0;
  logic reset_n;
  logic xclk;
  logic xclk_lock;
  logic pclk_rst_n;
  logic image_state;
  int   checks = 0;
  int   errors = 0;

  dvp_raw_frontend_if dvp ();

  dvp_raw_frontend #(
    .XCLK_DIV   (2),
    .LOCK_CYCLES(1024),
    .FRAME_SKIP (10)
  ) dut (
    .clk50m     (clk50m),
    .reset_n    (reset_n),
    .pclk       (pclk),
    .dvp        (dvp),
    .xclk       (xclk),
    .xclk_lock  (xclk_lock),
    .pclk_rst_n (pclk_rst_n),
    .image_state(image_state)
  );

  always #10 clk50m = ~clk50m;

  // pclk edges offset from clk50m edges so lock never coincides with pclk
  initial begin
    #5;
    forever #20 pclk = ~pclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge pclk);
    dvp.vsync = v;
    dvp.href  = h;
    dvp.data  = d;
    @(posedge pclk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, output int nvalid);
    nvalid = 0;
    for (int t = 0; t < 44; t++) begin
      logic h;
      h = (t >= 4) && (((t - 4) % 10) < 8);
      cyc(t < 2, h, d);
      if (dvp.data_valid === 1'b1) nvalid++;
    end
  endtask

  task automatic test_reset;
    dvp.vsync = 1'b0;
    dvp.href  = 1'b0;
    dvp.data  = 8'd0;
    reset_n   = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (5) @(negedge clk50m);
    checks++; if (xclk !== 1'b0) begin errors++; $display("FAIL rst_xclk got %b exp 0", xclk); end
    checks++; if (xclk_lock !== 1'b0) begin errors++; $display("FAIL rst_lock got %b exp 0", xclk_lock); end
    checks++; if (pclk_rst_n !== 1'b0) begin errors++; $display("FAIL rst_pclk_rst_n got %b exp 0", pclk_rst_n); end
    checks++; if (image_state !== 1'b1) begin errors++; $display("FAIL rst_image_state got %b exp 1", image_state); end
    checks++; if (dvp.data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", dvp.data_valid); end
    checks++; if (dvp.data_hs !== 1'b0) begin errors++; $display("FAIL rst_hs got %b exp 0", dvp.data_hs); end
    checks++; if (dvp.data_vs !== 1'b0) begin errors++; $display("FAIL rst_vs got %b exp 0", dvp.data_vs); end
    checks++; if (dvp.data_pixel !== 8'd0) begin errors++; $display("FAIL rst_pixel got %h exp 00", dvp.data_pixel); end
    checks++; if (dvp.xaddr !== 12'd0) begin errors++; $display("FAIL rst_xaddr got %0d exp 0", dvp.xaddr); end
    checks++; if (dvp.yaddr !== 12'd0) begin errors++; $display("FAIL rst_yaddr got %0d exp 0", dvp.yaddr); end
    @(posedge pclk); #1;
    checks++; if (dvp.data_clk !== 1'b1) begin errors++; $display("FAIL data_clk_high got %b exp 1", dvp.data_clk); end
    @(negedge pclk); #1;
    checks++; if (dvp.data_clk !== 1'b0) begin errors++; $display("FAIL data_clk_low got %b exp 0", dvp.data_clk); end
  endtask

  task automatic test_clock_lock;
    int bad_x   = 0;
    int bad_l   = 0;
    int rise_k  = -1;
    int edges   = -1;
    int rise_e  = -1;
    int bad_pre = 0;
    @(negedge clk50m);
    reset_n = 1'b1;
    fork
      begin
        logic exp_x;
        exp_x = 1'b0;
        for (int k = 1; k <= 2200; k++) begin
          @(posedge clk50m);
          exp_x = ~exp_x;
          @(negedge clk50m);
          if (xclk !== exp_x) bad_x++;
          if ((k <= 1022) && (xclk_lock !== 1'b0)) bad_l++;
          if ((k >= 1026) && (xclk_lock !== 1'b1)) bad_l++;
          if ((rise_k < 0) && (xclk_lock === 1'b1)) rise_k = k;
        end
      end
      begin
        for (int i = 0; (i < 1500) && (rise_e < 0); i++) begin
          @(posedge pclk);
          if ((edges < 0) && (xclk_lock === 1'b1)) edges = 0;
          if (edges >= 0) edges++;
          #1;
          if ((edges < 0) && (pclk_rst_n !== 1'b0)) bad_pre++;
          if ((edges >= 0) && (pclk_rst_n === 1'b1)) rise_e = edges;
        end
      end
    join
    checks++; if (bad_x != 0) begin errors++; $display("FAIL xclk_toggle bad_cycles %0d exp 0", bad_x); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL lock_level bad_cycles %0d exp 0", bad_l); end
    checks++; if ((rise_k < 1023) || (rise_k > 1025)) begin errors++; $display("FAIL lock_rise_cycle got %0d exp 1024+-1", rise_k); end
    checks++; if (bad_pre != 0) begin errors++; $display("FAIL pclk_rst_early bad_edges %0d exp 0", bad_pre); end
    checks++; if (rise_e != 2) begin errors++; $display("FAIL pclk_rst_release got %0d edges exp 2", rise_e); end
  endtask

  task automatic test_frame_skip;
    int vs_edges = 0;
    for (int f = 0; f < 12; f++) begin
      for (int t = 0; t < 44; t++) begin
        logic v, h, en, exp_valid;
        logic [7:0]  d, exp_pix;
        logic [11:0] exp_x, exp_y;
        int line, col;
        v = (t < 2); h = 1'b0; d = 8'd0; line = 0; col = 0;
        if (t >= 4) begin
          line = (t - 4) / 10;
          col  = (t - 4) % 10;
          h    = (col < 8);
          d    = h ? 8'(col) : 8'd0;
        end
        if (t == 0) vs_edges++;
        cyc(v, h, d);
        en        = (vs_edges >= 10);
        exp_valid = h & en;
        exp_pix   = exp_valid ? d : 8'd0;
        exp_x     = exp_valid ? 12'(col + 1) : 12'd0;
        exp_y     = (en && (t >= 4)) ? 12'(line + 1) : 12'd0;
        checks++; if (image_state !== !en) begin errors++; $display("FAIL skip_image_state f=%0d t=%0d got %b exp %b", f, t, image_state, !en); end
        checks++; if (dvp.data_valid !== exp_valid) begin errors++; $display("FAIL skip_valid f=%0d t=%0d got %b exp %b", f, t, dvp.data_valid, exp_valid); end
        checks++; if (dvp.data_hs !== exp_valid) begin errors++; $display("FAIL skip_hs f=%0d t=%0d got %b exp %b", f, t, dvp.data_hs, exp_valid); end
        checks++; if (dvp.data_vs !== (v & en)) begin errors++; $display("FAIL skip_vs f=%0d t=%0d got %b exp %b", f, t, dvp.data_vs, v & en); end
        checks++; if (dvp.data_pixel !== exp_pix) begin errors++; $display("FAIL skip_pixel f=%0d t=%0d got %h exp %h", f, t, dvp.data_pixel, exp_pix); end
        checks++; if (dvp.xaddr !== exp_x) begin errors++; $display("FAIL skip_xaddr f=%0d t=%0d got %0d exp %0d", f, t, dvp.xaddr, exp_x); end
        checks++; if (dvp.yaddr !== exp_y) begin errors++; $display("FAIL skip_yaddr f=%0d t=%0d got %0d exp %0d", f, t, dvp.yaddr, exp_y); end
      end
    end
  endtask

  task automatic test_enabled_frame;
    for (int t = 0; t < 44; t++) begin
      logic h;
      logic [11:0] exp_x, exp_y;
      int line, col;
      h = 1'b0; line = 0; col = 0;
      if (t >= 4) begin
        line = (t - 4) / 10;
        col  = (t - 4) % 10;
        h    = (col < 8);
      end
      cyc(t < 2, h, 8'hA5);
      exp_x = h ? 12'(col + 1) : 12'd0;
      exp_y = (t >= 4) ? 12'(line + 1) : 12'd0;
      checks++; if (dvp.data_pixel !== (h ? 8'hA5 : 8'h00)) begin errors++; $display("FAIL a5_pixel t=%0d got %h exp %h", t, dvp.data_pixel, h ? 8'hA5 : 8'h00); end
      checks++; if (dvp.data_valid !== h) begin errors++; $display("FAIL a5_valid t=%0d got %b exp %b", t, dvp.data_valid, h); end
      checks++; if (dvp.xaddr !== exp_x) begin errors++; $display("FAIL a5_xaddr t=%0d got %0d exp %0d", t, dvp.xaddr, exp_x); end
      checks++; if (dvp.yaddr !== exp_y) begin errors++; $display("FAIL a5_yaddr t=%0d got %0d exp %0d", t, dvp.yaddr, exp_y); end
    end
  endtask

  task automatic test_wide_line;
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    for (int k = 1; k <= 4100; k++) begin
      cyc(1'b0, 1'b1, 8'h3C);
      checks++; if (dvp.xaddr !== 12'(k)) begin errors++; $display("FAIL wide_xaddr k=%0d got %0d exp %0d", k, dvp.xaddr, 12'(k)); end
    end
    checks++; if (dvp.yaddr !== 12'd1) begin errors++; $display("FAIL wide_yaddr got %0d exp 1", dvp.yaddr); end
    cyc(1'b0, 1'b0, 8'd0);
    checks++; if (dvp.xaddr !== 12'd0) begin errors++; $display("FAIL wide_xaddr_end got %0d exp 0", dvp.xaddr); end
    checks++; if (dvp.data_valid !== 1'b0) begin errors++; $display("FAIL wide_valid_end got %b exp 0", dvp.data_valid); end
  endtask

  task automatic test_vs_overlap;
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'h11);
    checks++; if (dvp.yaddr !== 12'd1) begin errors++; $display("FAIL ovl_yaddr_pre got %0d exp 1", dvp.yaddr); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 8'h22);
      checks++; if (dvp.data_hs !== 1'b1) begin errors++; $display("FAIL ovl_hs i=%0d got %b exp 1", i, dvp.data_hs); end
      checks++; if (dvp.data_vs !== 1'b1) begin errors++; $display("FAIL ovl_vs i=%0d got %b exp 1", i, dvp.data_vs); end
      checks++; if (dvp.yaddr !== 12'd0) begin errors++; $display("FAIL ovl_yaddr i=%0d got %0d exp 0", i, dvp.yaddr); end
      checks++; if (dvp.data_pixel !== 8'h22) begin errors++; $display("FAIL ovl_pixel i=%0d got %h exp 22", i, dvp.data_pixel); end
    end
    cyc(1'b0, 1'b0, 8'd0);
    checks++; if (dvp.yaddr !== 12'd0) begin errors++; $display("FAIL ovl_yaddr_post got %0d exp 0", dvp.yaddr); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int nvalid = 0;
    int total_valid = 0;
    cyc(1'b1, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 8'h5B);
    checks++; if (dvp.data_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", dvp.data_valid); end
    #3;
    reset_n = 1'b0;
    #2;
    checks++; if (dvp.data_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", dvp.data_valid); end
    checks++; if (dvp.data_hs !== 1'b0) begin errors++; $display("FAIL mid_hs got %b exp 0", dvp.data_hs); end
    checks++; if (dvp.data_pixel !== 8'd0) begin errors++; $display("FAIL mid_pixel got %h exp 00", dvp.data_pixel); end
    checks++; if (dvp.xaddr !== 12'd0) begin errors++; $display("FAIL mid_xaddr got %0d exp 0", dvp.xaddr); end
    checks++; if (dvp.yaddr !== 12'd0) begin errors++; $display("FAIL mid_yaddr got %0d exp 0", dvp.yaddr); end
    checks++; if (image_state !== 1'b1) begin errors++; $display("FAIL mid_image_state got %b exp 1", image_state); end
    checks++; if (pclk_rst_n !== 1'b0) begin errors++; $display("FAIL mid_pclk_rst_n got %b exp 0", pclk_rst_n); end
    checks++; if (xclk_lock !== 1'b0) begin errors++; $display("FAIL mid_lock got %b exp 0", xclk_lock); end
    checks++; if (xclk !== 1'b0) begin errors++; $display("FAIL mid_xclk got %b exp 0", xclk); end
    dvp.vsync = 1'b0;
    dvp.href  = 1'b0;
    dvp.data  = 8'd0;
    repeat (4) @(negedge clk50m);
    reset_n = 1'b1;
    while ((xclk_lock !== 1'b1) && (n < 1100)) begin
      @(negedge clk50m);
      n++;
    end
    checks++; if (xclk_lock !== 1'b1) begin errors++; $display("FAIL mid_relock got %b exp 1", xclk_lock); end
    n = 0;
    while ((pclk_rst_n !== 1'b1) && (n < 10)) begin
      @(posedge pclk); #1;
      n++;
    end
    checks++; if (pclk_rst_n !== 1'b1) begin errors++; $display("FAIL mid_pclk_release got %b exp 1", pclk_rst_n); end
    for (int f = 0; f < 9; f++) begin
      send_frame(8'h77, nvalid);
      total_valid += nvalid;
    end
    checks++; if (total_valid != 0) begin errors++; $display("FAIL mid_skip_valid got %0d cycles exp 0", total_valid); end
    checks++; if (image_state !== 1'b1) begin errors++; $display("FAIL mid_skip9_state got %b exp 1", image_state); end
    cyc(1'b1, 1'b0, 8'd0);
    checks++; if (image_state !== 1'b0) begin errors++; $display("FAIL mid_skip10_state got %b exp 0", image_state); end
    checks++; if (dvp.data_vs !== 1'b1) begin errors++; $display("FAIL mid_skip10_vs got %b exp 1", dvp.data_vs); end
    cyc(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_clock_lock();
    test_frame_skip();
    test_enabled_frame();
    test_wide_line();
    test_vs_overlap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
